// File: rtl/score_pkg.sv
// score_pkg: shared types and BCD point values for the score feeder.
package score_pkg;

  typedef enum logic [1:0] {
    HIT_LARGE  = 2'd0,
    HIT_MEDIUM = 2'd1,
    HIT_SMALL  = 2'd2,
    HIT_SAUCER = 2'd3
  } hit_kind_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } feeder_state_t;

  // Three BCD digits are enough for every point value.
  localparam logic [11:0] PTS_LARGE  = 12'h020;
  localparam logic [11:0] PTS_MEDIUM = 12'h050;
  localparam logic [11:0] PTS_SMALL  = 12'h100;
  localparam logic [11:0] PTS_SAUCER = 12'h200;

  function automatic logic [11:0] kind_points(input hit_kind_t kind);
    case (kind)
      HIT_LARGE:  return PTS_LARGE;
      HIT_MEDIUM: return PTS_MEDIUM;
      HIT_SMALL:  return PTS_SMALL;
      default:    return PTS_SAUCER;
    endcase
  endfunction

endpackage

// File: rtl/score_fifo.sv
// score_fifo: small synchronous FIFO holding hit kinds, with full/empty/count.
// Callers only push when not full (or when popping the same cycle) and only pop when not empty.
module score_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       resetN,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Next-state for storage, pointers and occupancy; pointers wrap since DEPTH is a power of 2.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Storage holds data only, so it needs no reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: rtl/score_feeder.sv
// score_feeder: queues hit events and feeds BCD addends to score_box one at a time.
// Optional: SCORE_EXTRA_LIFE_EN enables extra-life detection on score_in; otherwise
// extra_life is tied low and score_in is ignored.
module score_feeder
  import score_pkg::*;
#(
  parameter int DIGITS     = 5,
  parameter int FIFO_DEPTH = 4,
  parameter int ADD_GAP    = 8,
  parameter int LIFE_DIGIT = 4
) (
  input  logic                          clk,
  input  logic                          resetN,
  input  logic                          hit_valid,
  input  logic [1:0]                    hit_kind,
  output logic                          hit_dropped,
  output logic                          add,
  output logic [DIGITS-1:0][3:0]        sum,
  input  logic [DIGITS-1:0][3:0]        score_in,
  output logic [$clog2(FIFO_DEPTH):0]   pending,
  output logic                          extra_life
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int GAP_W = $clog2(ADD_GAP) + 1;

  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [1:0]       head_kind;
  logic [CNT_W-1:0] fifo_count;

  feeder_state_t           state_q, state_d;
  logic [GAP_W-1:0]        gap_q, gap_d;
  logic                    add_q, add_d;
  logic [DIGITS-1:0][3:0]  sum_q, sum_d;
  logic                    hit_dropped_q, hit_dropped_d;

  score_fifo #(
    .WIDTH (2),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .resetN (resetN),
    .push   (fifo_push),
    .pop    (fifo_pop),
    .wdata  (hit_kind),
    .rdata  (head_kind),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (fifo_count)
  );

  // Issue FSM: the head is popped as the FSM enters ISSUE, so add is high exactly while in
  // ISSUE; WAIT then holds off ADD_GAP-1 cycles plus one IDLE cycle before the next add.
  always_comb begin
    state_d       = state_q;
    gap_d         = gap_q;
    add_d         = 1'b0;
    sum_d         = '0;
    fifo_pop      = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          add_d      = 1'b1;
          sum_d[2:0] = kind_points(hit_kind_t'(head_kind));
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        gap_d   = GAP_W'(ADD_GAP - 1);
        state_d = WAIT;
      end
      WAIT: begin
        gap_d = gap_q - 1'b1;
        if (gap_d == '0) begin
          state_d = IDLE;
        end
      end
      default: begin
        gap_d   = '0;
        state_d = IDLE;
      end
    endcase
    // A full queue still accepts a hit when the head leaves in the same cycle.
    fifo_push     = hit_valid && (!fifo_full || fifo_pop);
    hit_dropped_d = hit_valid && !fifo_push;
  end

  // FSM, gap counter and registered outputs.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q       <= IDLE;
      gap_q         <= '0;
      add_q         <= 1'b0;
      sum_q         <= '0;
      hit_dropped_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      gap_q         <= gap_d;
      add_q         <= add_d;
      sum_q         <= sum_d;
      hit_dropped_q <= hit_dropped_d;
    end
  end

  assign add         = add_q;
  assign sum         = sum_q;
  assign hit_dropped = hit_dropped_q;
  assign pending     = fifo_count;

`ifdef SCORE_EXTRA_LIFE_EN
  logic [3:0] life_shadow_q, life_shadow_d;
  logic       extra_life_q, extra_life_d;

  // Any change of the watched digit, including a 9->0 rollover, grants one life.
  always_comb begin
    life_shadow_d = score_in[LIFE_DIGIT];
    extra_life_d  = (score_in[LIFE_DIGIT] != life_shadow_q);
  end

  // Shadow of the watched digit and the registered life pulse.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      life_shadow_q <= '0;
      extra_life_q  <= 1'b0;
    end else begin
      life_shadow_q <= life_shadow_d;
      extra_life_q  <= extra_life_d;
    end
  end

  assign extra_life = extra_life_q;
`else
  assign extra_life = 1'b0;
`endif

  // Only one digit of score_in is watched, and none when the feature is off.
  logic unused_score;
  assign unused_score = ^score_in;

endmodule

// File: tb/tb_score_feeder.sv
// tb_score_feeder: directed bench for score_feeder with a behavioural score_box model.
module tb_score_feeder;

`ifdef SCORE_EXTRA_LIFE_EN
  localparam int EXP_LIFE = 1;
`else
  localparam int EXP_LIFE = 0;
`endif

  logic            clk = 1'b0;
  logic            resetN;
  logic            hit_valid;
  logic [1:0]      hit_kind;
  logic            hit_dropped;
  logic            add;
  logic [4:0][3:0] sum;
  logic [4:0][3:0] score;
  logic [2:0]      pending;
  logic            extra_life;

  logic            preset_en;
  logic [19:0]     preset_val;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int add_n = 0;
  int life_n = 0;
  int consec = 0;
  logic prev_add = 1'b0;
  int add_cyc [16];
  logic [19:0] add_sum [16];

  int base;
  logic [19:0] exp_sums [6];

  score_feeder dut (
    .clk         (clk),
    .resetN      (resetN),
    .hit_valid   (hit_valid),
    .hit_kind    (hit_kind),
    .hit_dropped (hit_dropped),
    .add         (add),
    .sum         (sum),
    .score_in    (score),
    .pending     (pending),
    .extra_life  (extra_life)
  );

  always #5 clk = ~clk;

  function automatic logic [19:0] bcd_add(input logic [19:0] a, input logic [19:0] b);
    logic [19:0] r;
    logic [4:0]  d;
    logic [4:0]  t;
    logic        c;
    r = '0;
    c = 1'b0;
    for (int i = 0; i < 5; i++) begin
      d = {1'b0, a[i*4 +: 4]} + {1'b0, b[i*4 +: 4]} + {4'd0, c};
      if (d > 5'd9) begin
        t = d - 5'd10;
        r[i*4 +: 4] = t[3:0];
        c = 1'b1;
      end else begin
        r[i*4 +: 4] = d[3:0];
        c = 1'b0;
      end
    end
    return r;
  endfunction

  // score_box stand-in: adds sum on each add pulse, with a bench-controlled preset.
  always @(posedge clk) begin
    if (preset_en) score <= preset_val;
    else if (add)  score <= bcd_add(score, sum);
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Record every add pulse and extra-life pulse away from the clock edge.
  always @(negedge clk) begin
    if (add) begin
      if (add_n < 16) begin
        add_cyc[add_n] <= cyc;
        add_sum[add_n] <= sum;
      end
      add_n <= add_n + 1;
    end
    if (add && prev_add) consec <= consec + 1;
    prev_add <= add;
    if (extra_life) life_n <= life_n + 1;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  initial begin
    exp_sums = '{20'h00050, 20'h00020, 20'h00050, 20'h00100, 20'h00200, 20'h00050};
    resetN     = 1'b0;
    hit_valid  = 1'b0;
    hit_kind   = 2'd0;
    preset_en  = 1'b1;
    preset_val = 20'h00000;
    tick(3);
    check("rst_add", 32'(add), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_pending", 32'(pending), 32'd0);
    check("rst_dropped", 32'(hit_dropped), 32'd0);
    check("rst_life", 32'(extra_life), 32'd0);
    preset_en = 1'b0;
    resetN    = 1'b1;
    tick(2);

    // Single medium hit: add two cycles after the strobe.
    hit_valid = 1'b1; hit_kind = 2'd1;
    tick(1);
    hit_valid = 1'b0;
    check("single_pending", 32'(pending), 32'd1);
    check("single_add_early", 32'(add), 32'd0);
    tick(1);
    check("single_add", 32'(add), 32'd1);
    check("single_sum", 32'(sum), 32'h00050);
    check("single_pending0", 32'(pending), 32'd0);

    // Burst of five hits while the feeder waits: the fifth is dropped.
    hit_valid = 1'b1; hit_kind = 2'd0;
    tick(1);
    check("add_one_cycle", 32'(add), 32'd0);
    check("sum_cleared", 32'(sum), 32'd0);
    check("score_50", 32'(score), 32'h00050);
    hit_kind = 2'd1; tick(1);
    hit_kind = 2'd2; tick(1);
    hit_kind = 2'd3; tick(1);
    check("burst_full", 32'(pending), 32'd4);
    hit_kind = 2'd0; tick(1);
    hit_valid = 1'b0;
    check("burst_dropped", 32'(hit_dropped), 32'd1);
    check("burst_pending", 32'(pending), 32'd4);
    tick(1);
    check("dropped_pulse", 32'(hit_dropped), 32'd0);
    tick(2);
    check("idle_no_add", 32'(add), 32'd0);
    check("idle_pending", 32'(pending), 32'd4);

    // Hit on a full queue in the same cycle as the pop is accepted.
    hit_valid = 1'b1; hit_kind = 2'd1;
    tick(1);
    hit_valid = 1'b0;
    check("pop_push_add", 32'(add), 32'd1);
    check("pop_push_sum", 32'(sum), 32'h00020);
    check("pop_push_pending", 32'(pending), 32'd4);
    check("pop_push_no_drop", 32'(hit_dropped), 32'd0);
    tick(50);
    check("burst_score", 32'(score), 32'h00470);
    check("burst_add_count", 32'(add_n), 32'd6);
    check("no_back_to_back", 32'(consec), 32'd0);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("add_sum_%0d", i), 32'(add_sum[i]), 32'(exp_sums[i]));
    end
    for (int i = 1; i < 6; i++) begin
      check($sformatf("add_gap_%0d", i), 32'(add_cyc[i] - add_cyc[i-1]), 32'd9);
    end

    // 09950 + 100 crosses 10,000.
    preset_en = 1'b1; preset_val = 20'h09950;
    tick(1);
    preset_en = 1'b0;
    tick(3);
    base = life_n;
    hit_valid = 1'b1; hit_kind = 2'd2;
    tick(1);
    hit_valid = 1'b0;
    tick(15);
    check("life_score", 32'(score), 32'h10050);
    check("life_pulses", 32'(life_n - base), 32'(EXP_LIFE));

    // 99900 + 200 wraps to 00100 and still grants a life.
    preset_en = 1'b1; preset_val = 20'h99900;
    tick(1);
    preset_en = 1'b0;
    tick(3);
    base = life_n;
    hit_valid = 1'b1; hit_kind = 2'd3;
    tick(1);
    hit_valid = 1'b0;
    tick(15);
    check("wrap_score", 32'(score), 32'h00100);
    check("wrap_pulses", 32'(life_n - base), 32'(EXP_LIFE));
    check("life_idle", 32'(extra_life), 32'd0);

    // Reset while waiting with three events queued.
    base = add_n;
    hit_valid = 1'b1; hit_kind = 2'd0;
    tick(4);
    hit_valid = 1'b0;
    check("pre_rst_pending", 32'(pending), 32'd3);
    check("pre_rst_adds", 32'(add_n - base), 32'd1);
    resetN = 1'b0;
    #1;
    check("mid_rst_add", 32'(add), 32'd0);
    check("mid_rst_sum", 32'(sum), 32'd0);
    check("mid_rst_pending", 32'(pending), 32'd0);
    check("mid_rst_dropped", 32'(hit_dropped), 32'd0);
    check("mid_rst_life", 32'(extra_life), 32'd0);
    tick(3);
    resetN = 1'b1;
    tick(25);
    check("post_rst_adds", 32'(add_n - base), 32'd1);
    check("post_rst_pending", 32'(pending), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
